// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline boundary register with valid/ready handshake, a 2-entry skid buffer,
// synchronous flush and x0-write suppression. Optional forwarding port: MEM_WB_FWD_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] wD_i,
  input  logic [REG_AW-1:0] wR_i,
  input  logic              rf_we_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] wD_o,
  output logic [REG_AW-1:0] wR_o,
  output logic              rf_we_o
`ifdef MEM_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0] fwd_rs_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);

  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [REG_AW-1:0] outReg_q, outReg_d;
  logic              outWe_q, outWe_d;
  logic              skdValid_q, skdValid_d;
  logic [DATA_W-1:0] skdData_q, skdData_d;
  logic [REG_AW-1:0] skdReg_q, skdReg_d;
  logic              skdWe_q, skdWe_d;

  logic accept;
  logic drain;

  // ready_o comes straight from a flop, so it never sees ready_i combinationally
  assign ready_o = ~skdValid_q;
  assign accept  = valid_i & ready_o;
  assign drain   = outValid_q & ready_i;

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outReg_d   = outReg_q;
    outWe_d    = outWe_q;
    skdValid_d = skdValid_q;
    skdData_d  = skdData_q;
    skdReg_d   = skdReg_q;
    skdWe_d    = skdWe_q;

    if (flush_i) begin
      outValid_d = 1'b0;
      skdValid_d = 1'b0;
    end else if (drain || !outValid_q) begin
      // OUT is free this cycle: refill from SKD first to keep order, else from input
      if (skdValid_q) begin
        outValid_d = 1'b1;
        outData_d  = skdData_q;
        outReg_d   = skdReg_q;
        outWe_d    = skdWe_q;
        skdValid_d = 1'b0;
      end else if (accept) begin
        outValid_d = 1'b1;
        outData_d  = wD_i;
        outReg_d   = wR_i;
        outWe_d    = rf_we_i;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skdValid_d = 1'b1;
      skdData_d  = wD_i;
      skdReg_d   = wR_i;
      skdWe_d    = rf_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outReg_q   <= '0;
      outWe_q    <= 1'b0;
      skdValid_q <= 1'b0;
      skdData_q  <= '0;
      skdReg_q   <= '0;
      skdWe_q    <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outReg_q   <= outReg_d;
      outWe_q    <= outWe_d;
      skdValid_q <= skdValid_d;
      skdData_q  <= skdData_d;
      skdReg_q   <= skdReg_d;
      skdWe_q    <= skdWe_d;
    end
  end

  assign valid_o = outValid_q;
  assign wD_o    = outData_q;
  assign wR_o    = outReg_q;
  assign rf_we_o = outValid_q & outWe_q & (outReg_q != '0);

`ifdef MEM_WB_FWD_EN
  // Only OUT is searched; rf_we_o already excludes x0, so fwd_rs_i=0 can never hit
  assign fwd_hit_o  = rf_we_o & (outReg_q == fwd_rs_i);
  assign fwd_data_o = fwd_hit_o ? outData_q : '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed + random bench for mem_wb_stage; a queue models the entries held in the stage.
module tb_mem_wb_stage;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  r;
    logic        e;
  } entry_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i, flush_i, valid_i, ready_i, rf_we_i;
  logic [31:0] wD_i;
  logic [4:0]  wR_i;
  logic        ready_o, valid_o, rf_we_o;
  logic [31:0] wD_o;
  logic [4:0]  wR_o;
`ifdef MEM_WB_FWD_EN
  logic [4:0]  fwd_rs_i = '0;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
`endif

  entry_t sbQueue[$];
  int     checkCount = 0;
  int     errorCount = 0;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .wD_i(wD_i), .wR_i(wR_i), .rf_we_i(rf_we_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .wD_o(wD_o), .wR_o(wR_o), .rf_we_o(rf_we_o)
`ifdef MEM_WB_FWD_EN
    , .fwd_rs_i(fwd_rs_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] r,
                               input logic e);
    valid_i = v;
    wD_i    = d;
    wR_i    = r;
    rf_we_i = e;
  endtask

  // Compare outputs with the model before the edge, then advance the model across it
  task automatic stepCycle();
    bit     acc, drn, rstNow, flushNow;
    entry_t inE;
    acc = 1'b0;
    drn = 1'b0;
    rstNow = !rst_n_i;
    flushNow = flush_i;
    inE.d = wD_i;
    inE.r = wR_i;
    inE.e = rf_we_i && (wR_i != 5'd0);
    if (!rstNow) begin
      checkOutput("valid_o", 32'(valid_o), 32'(sbQueue.size() > 0));
      checkOutput("ready_o", 32'(ready_o), 32'(sbQueue.size() < 2));
      if (sbQueue.size() > 0) begin
        checkOutput("wD_o", wD_o, sbQueue[0].d);
        checkOutput("wR_o", 32'(wR_o), 32'(sbQueue[0].r));
        checkOutput("rf_we_o", 32'(rf_we_o), 32'(sbQueue[0].e));
      end else begin
        checkOutput("rf_we_o idle", 32'(rf_we_o), 32'd0);
      end
      acc = valid_i && (sbQueue.size() < 2);
      drn = (sbQueue.size() > 0) && ready_i;
    end
    @(posedge clk_i);
    #1;
    if (rstNow || flushNow) begin
      sbQueue.delete();
    end else begin
      if (drn) void'(sbQueue.pop_front());
      if (acc) sbQueue.push_back(inE);
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1);
    #1;

    $display("[TB] reset with valid_i held high");
    stepCycle();
    stepCycle();
    rst_n_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset wD_o", wD_o, 32'd0);
    checkOutput("reset wR_o", 32'(wR_o), 32'd0);
    checkOutput("reset rf_we_o", 32'(rf_we_o), 32'd0);
    checkOutput("reset ready_o", 32'(ready_o), 32'd1);
    stepCycle();

    $display("[TB] single entry flow");
    applyStimulus(1'b1, 32'h1234, 5'd5, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    checkOutput("flow valid_o", 32'(valid_o), 32'd1);
    checkOutput("flow wD_o", wD_o, 32'h1234);
    checkOutput("flow wR_o", 32'(wR_o), 32'd5);
    checkOutput("flow rf_we_o", 32'(rf_we_o), 32'd1);
    stepCycle();
    stepCycle();

    $display("[TB] back-pressure into skid buffer");
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'hA, 5'd1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 32'hB, 5'd2, 1'b1);
    stepCycle();
    checkOutput("bp ready_o after B", 32'(ready_o), 32'd0);
    applyStimulus(1'b1, 32'hC, 5'd3, 1'b1);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    ready_i = 1'b1;
    checkOutput("bp A at head", wD_o, 32'hA);
    stepCycle();
    checkOutput("bp B follows", wD_o, 32'hB);
    checkOutput("bp ready_o restored", 32'(ready_o), 32'd1);
    stepCycle();
    stepCycle();

    $display("[TB] flush while full");
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'h11, 5'd4, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 32'h22, 5'd6, 1'b1);
    stepCycle();
    flush_i = 1'b1;
    applyStimulus(1'b1, 32'h33, 5'd7, 1'b1);
    stepCycle();
    flush_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    checkOutput("flush valid_o", 32'(valid_o), 32'd0);
    checkOutput("flush ready_o", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    repeat (3) stepCycle();

    $display("[TB] x0 write suppression and bubble");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 32'h77, 5'd9, 1'b0);
    checkOutput("x0 valid_o", 32'(valid_o), 32'd1);
    checkOutput("x0 rf_we_o", 32'(rf_we_o), 32'd0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    stepCycle();
    stepCycle();

`ifdef MEM_WB_FWD_EN
    $display("[TB] forwarding from OUT");
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'h55, 5'd7, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    fwd_rs_i = 5'd7;
    #1;
    checkOutput("fwd hit", 32'(fwd_hit_o), 32'd1);
    checkOutput("fwd data", fwd_data_o, 32'h55);
    fwd_rs_i = 5'd6;
    #1;
    checkOutput("fwd miss hit", 32'(fwd_hit_o), 32'd0);
    checkOutput("fwd miss data", fwd_data_o, 32'd0);
    fwd_rs_i = 5'd0;
    #1;
    checkOutput("fwd x0 hit", 32'(fwd_hit_o), 32'd0);
    ready_i = 1'b1;
    stepCycle();
    stepCycle();
`endif

    $display("[TB] reset while full");
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'h44, 5'd8, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 32'h45, 5'd9, 1'b1);
    stepCycle();
    rst_n_i = 1'b0;
    stepCycle();
    rst_n_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    checkOutput("midreset wD_o", wD_o, 32'd0);
    checkOutput("midreset wR_o", 32'(wR_o), 32'd0);
    ready_i = 1'b1;
    stepCycle();

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 3) != 0));
      ready_i = 1'($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 40) == 0);
      stepCycle();
    end
    flush_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    ready_i = 1'b1;
    repeat (4) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
